// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// default address/instruction widths, the reset PC and the NOP encoding
// used to fill an empty IF/ID register.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int          ADDR_W_DEF   = 8;
    localparam int          INSTR_W_DEF  = 32;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;

    // addi x0, x0, 0 -- what the decode stage sees while IF/ID holds a bubble
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        HELD     = 2'd2,
        REDIRECT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register. Loads a {pc, instruction} pair, holds it, or is
// flushed to a bubble (valid cleared, instruction replaced by NOP).
// Flush wins over load.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   load_i   in   capture pc_i / instr_i and mark valid
//   flush_i  in   turn the register into a bubble
//   pc_i     in   PC of the instruction being loaded
//   instr_i  in   instruction being loaded
//   pc_o     out  PC of the held instruction
//   instr_o  out  held instruction
//   valid_o  out  1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (flush_i) begin
            // The PC field is left alone; only valid/instr mark the bubble.
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program counter and fetch sequencer. Presents the PC to the external
// incrementer/branch mux and loads its result back, handshakes with the
// instruction memory, and fills the IF/ID register. A stall that arrives
// together with a returning instruction parks that instruction in a
// one-entry skid buffer so memory never has to replay it. A taken branch
// flushes IF/ID and the skid buffer and costs one idle request cycle.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   pc          out  current PC (to the incrementer)
//   next_addr   in   PC+4 or branch target from the incrementer mux
//   pcsrc       in   taken-branch redirect
//   stall       in   hazard-unit hold for IF and IF/ID
//   imem_req    out  fetch request
//   imem_addr   out  fetch address (always equals pc)
//   imem_ready  in   imem_rdata valid this cycle
//   imem_rdata  in   fetched instruction
//   ifid_pc     out  PC of the instruction in IF/ID
//   ifid_instr  out  instruction in IF/ID
//   ifid_valid  out  IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter int                 INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  next_addr,
    input  logic               pcsrc,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               req_q;
    logic [ADDR_W-1:0]  skid_pc_q;
    logic [INSTR_W-1:0] skid_instr_q;
    logic               skid_valid_q;

    // IF/ID control for this cycle
    logic               ifid_load_d;
    logic               ifid_flush_d;
    logic [ADDR_W-1:0]  ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_d;

    always_comb begin
        ifid_load_d  = 1'b0;
        ifid_flush_d = 1'b0;
        ifid_pc_d    = pc_q;
        ifid_instr_d = imem_rdata;
        case (state_q)
            FETCH: begin
                if (pcsrc) begin
                    ifid_flush_d = 1'b1;
                end else if (imem_ready && !stall) begin
                    ifid_load_d = 1'b1;
                end else if (!imem_ready && !stall) begin
                    // memory is still busy: hand decode a bubble
                    ifid_flush_d = 1'b1;
                end
            end
            HELD: begin
                if (pcsrc) begin
                    ifid_flush_d = 1'b1;
                end else if (!stall && skid_valid_q) begin
                    ifid_load_d  = 1'b1;
                    ifid_pc_d    = skid_pc_q;
                    ifid_instr_d = skid_instr_q;
                end
            end
            REDIRECT: begin
                if (pcsrc) begin
                    ifid_flush_d = 1'b1;
                end
            end
            default: begin
                // BOOT: nothing reaches IF/ID, redirects are ignored
            end
        endcase
    end

    // Fetch FSM, PC register and skid buffer. imem_req is registered and is
    // set exactly when the next state is FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= INSTR_W'(NOP_INSTR);
            skid_valid_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (pcsrc) begin
                        pc_q         <= next_addr;
                        skid_valid_q <= 1'b0;
                        state_q      <= REDIRECT;
                        req_q        <= 1'b0;
                    end else if (imem_ready) begin
                        if (!stall) begin
                            pc_q <= next_addr;
                        end else begin
                            // Instruction arrived but decode is blocked:
                            // park it and stop requesting.
                            skid_pc_q    <= pc_q;
                            skid_instr_q <= imem_rdata;
                            skid_valid_q <= 1'b1;
                            state_q      <= HELD;
                            req_q        <= 1'b0;
                        end
                    end
                end
                HELD: begin
                    if (pcsrc) begin
                        pc_q         <= next_addr;
                        skid_valid_q <= 1'b0;
                        state_q      <= REDIRECT;
                        req_q        <= 1'b0;
                    end else if (!stall) begin
                        // pc still names the parked instruction, so
                        // next_addr is its successor
                        pc_q         <= next_addr;
                        skid_valid_q <= 1'b0;
                        state_q      <= FETCH;
                        req_q        <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (pcsrc) begin
                        // back-to-back redirect restarts the idle cycle
                        pc_q    <= next_addr;
                        req_q   <= 1'b0;
                    end else begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= BOOT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    ifid_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_ifid_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ifid_load_d),
        .flush_i (ifid_flush_d),
        .pc_i    (ifid_pc_d),
        .instr_i (ifid_instr_d),
        .pc_o    (ifid_pc),
        .instr_o (ifid_instr),
        .valid_o (ifid_valid)
    );

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign imem_req  = req_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the 8-bit-address pipeline. It drives the current PC into the PC-increment/branch mux and loads that block's next address back into the PC. It runs the handshake with instruction memory and fills the IF/ID pipeline register. Stall from the hazard unit holds the stage; a taken branch (PCsrc) flushes it.

## Interface
Parameters:
- ADDR_W, 8, PC / instruction-memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- pc  out  ADDR_W  current PC; feeds the incrementer's current-address input
- next_addr  in  ADDR_W  incrementer mux output: PC+4, or the branch target when pcsrc=1
- pcsrc  in  1  taken-branch redirect (branch AND zero)
- stall  in  1  hazard-unit hold request for IF and IF/ID
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address; always equals pc
- imem_ready  in  1  imem_rdata valid this cycle (only meaningful while imem_req=1)
- imem_rdata  in  INSTR_W  fetched instruction
- ifid_pc  out  ADDR_W  PC of the instruction held in IF/ID
- ifid_instr  out  INSTR_W  instruction held in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Reset values: pc=RESET_PC, state=BOOT, imem_req=0, ifid_valid=0, ifid_pc=0, ifid_instr=NOP (32'h00000013), skid buffer empty.
- States: BOOT, FETCH, HELD, REDIRECT.
- BOOT: imem_req=0 for one cycle, then go to FETCH unconditionally.
- FETCH: imem_req=1.
  - imem_ready=1 and stall=0: IF/ID <= {pc, imem_rdata}; ifid_valid <= 1; pc <= next_addr; stay in FETCH.
  - imem_ready=1 and stall=1: the skid buffer captures {pc, imem_rdata}; IF/ID and pc hold; go to HELD.
  - imem_ready=0 and stall=0: ifid_valid <= 0 (bubble); pc holds.
  - imem_ready=0 and stall=1: everything holds.
- HELD: imem_req=0. When stall=0: IF/ID <= skid buffer; ifid_valid <= 1; pc <= next_addr; go to FETCH.
- REDIRECT: imem_req=0 for one cycle, then go to FETCH.
- pcsrc=1, in any state except BOOT:
  - Highest priority; overrides stall and imem_ready.
  - pc <= next_addr (the branch target); ifid_valid <= 0; skid buffer cleared; go to REDIRECT.
  - Any imem_rdata arriving in that same cycle is discarded.
- pcsrc=1 during BOOT: ignored.
- Memory protocol: imem_addr stays stable while imem_req=1 and imem_ready=0. The PC changes only on an accepted fetch, a HELD release, or a redirect. imem_req is never 1 in the cycle after a redirect.
- Arithmetic: this block performs no addition. pc is loaded verbatim from next_addr, so 8'hFC → 8'h00 wrap is inherited from the incrementer.
- While stall=1 and pcsrc=0, ifid_pc, ifid_instr and ifid_valid hold their values.

## Timing
- The first imem_req=1 occurs in the second cycle after rst_n rises.
- Zero-wait memory (imem_ready=1 in the request cycle): IF/ID updates at the end of that cycle. Throughput is 1 instruction per cycle.
- k-wait memory: ifid_valid=0 for k cycles, then the instruction appears on the edge ending the ready cycle.
- Redirect penalty: pcsrc in cycle N → imem_req=0 in cycle N+1 → the target is requested in cycle N+2.
- Asserting rst_n low mid-fetch forces all reset values immediately, without waiting for a clock edge. Any imem response arriving during reset is ignored.

## Structure
- Package fetch_pkg:
  - state enum (BOOT, FETCH, HELD, REDIRECT)
  - ADDR_W and INSTR_W defaults
  - NOP_INSTR = 32'h00000013
  - RESET_PC default
- Sub-module ifid_reg: IF/ID register with load, hold and flush-to-bubble controls, and async active-low reset. The FSM, PC register and skid buffer stay in pc_fetch_unit.

## Test plan
- Reset, then zero-wait memory with next_addr=pc+4 → imem_addr sequence 00,04,08,0C; ifid_pc lags by one cycle; ifid_valid=1 from the third cycle after reset release.
- imem_ready delayed 2 cycles at pc=8'h10 → imem_addr held at 10; ifid_valid=0 for 2 cycles; then ifid_pc=10 with the correct data.
- stall=1 for 3 cycles while imem_ready=1 at pc=8'h20 → state goes to HELD with imem_req=0; IF/ID holds; on release ifid_pc=20 and pc=24.
- pcsrc=1 with next_addr=8'h40 while stalled in HELD → ifid_valid=0, skid buffer dropped, imem_req=0 for one cycle, then imem_addr=40.
- pc=8'hFC with next_addr=8'h00 → pc wraps to 00 after the FC fetch; ifid_pc=FC.
- rst_n pulsed low mid-wait at pc=8'h30 → pc=00, ifid_valid=0, imem_req=0 asynchronously; normal fetch resumes from 00.
